// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters, coordinate outputs
// and a registered output stage that aligns blanked video with the sync pulses.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pixel_in,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       pix_ce,
  output logic       frame_start,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       vga_pixel
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_cnt, v_cnt;
  logic [9:0]       h_next, v_next;
  logic             h_wrap, v_wrap, active;

  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    v_wrap = (v_cnt == V_LAST);
    h_next = h_wrap ? 10'd0 : h_cnt + 10'd1;
    v_next = v_cnt;
    if (h_wrap) begin
      v_next = v_wrap ? 10'd0 : v_cnt + 10'd1;
    end
    active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  end

  assign pix_ce      = (div_cnt == DIV_LAST);
  assign frame_start = pix_ce && h_wrap && v_wrap;

  // x/y load from the next counter values so they always equal the live counters;
  // the output stage samples the live counters, hence lags x/y by one pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      x         <= '0;
      y         <= '0;
      video_on  <= 1'b0;
      vga_pixel <= 1'b0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
    end else begin
      div_cnt <= pix_ce ? '0 : div_cnt + DIV_W'(1);
      if (pix_ce) begin
        h_cnt     <= h_next;
        v_cnt     <= v_next;
        x         <= (h_next < H_ACT) ? h_next : 10'd0;
        y         <= (v_next < V_ACT) ? v_next[8:0] : 9'd0;
        video_on  <= active;
        vga_pixel <= pixel_in & active;
        hsync     <= ~((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        vsync     <= ~((v_cnt >= VS_BEG) && (v_cnt < VS_END));
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a scaled-down raster: a time-based
// reference model checked every cycle, plus literal period/pulse-width checks.
module tb_vga_timing_gen;

  localparam int CD  = 3;
  localparam int HA  = 16, HFP = 4, HS = 6, HBP = 4;
  localparam int VA  = 8,  VFP = 2, VS = 2, VBP = 3;
  localparam int HT  = HA + HFP + HS + HBP;   // 30
  localparam int VT  = VA + VFP + VS + VBP;   // 15
  localparam int FRAME_CLKS = CD * HT * VT;   // 1350

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pixel_in = 1'b0;
  logic [9:0] x;
  logic [8:0] y;
  logic       pix_ce, frame_start, video_on, hsync, vsync, vga_pixel;

  int n_chk = 0;
  int n_fail = 0;
  int mode = 0;   // 0 random pixel_in, 1 tied high, 2 renderer drawing x==5

  vga_timing_gen #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .x(x), .y(y), .pix_ce(pix_ce),
    .frame_start(frame_start), .video_on(video_on), .hsync(hsync), .vsync(vsync),
    .vga_pixel(vga_pixel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: clocks since reset -> pixel index -> raster position.
  // The output stage holds what the previous pixel period looked like.
  int  t = 0;
  bit  armed = 0;
  bit  pv = 0;
  int  ph, pvv;
  bit  ppix;

  always @(posedge clk) begin
    if (rst) begin
      t = 0; pv = 0; armed = 1;
    end else if (armed) begin
      if (t % CD == CD - 1) begin
        pv = 1; ph = (t / CD) % HT; pvv = (t / CD / HT) % VT; ppix = pixel_in;
      end
      t++;
    end
  end

  int mh, mv;
  bit mce, mact;
  always @(negedge clk) begin
    if (armed) begin
      mh  = (t / CD) % HT;
      mv  = (t / CD / HT) % VT;
      mce = (t % CD) == CD - 1;
      check("pix_ce", int'(pix_ce), int'(mce));
      check("frame_start", int'(frame_start), int'(mce && mh == HT - 1 && mv == VT - 1));
      check("x", int'(x), (mh < HA) ? mh : 0);
      check("y", int'(y), (mv < VA) ? mv : 0);
      if (pv) begin
        mact = (ph < HA) && (pvv < VA);
        check("video_on", int'(video_on), int'(mact));
        check("vga_pixel", int'(vga_pixel), int'(ppix && mact));
        check("hsync", int'(hsync), int'(!(ph >= HA + HFP && ph < HA + HFP + HS)));
        check("vsync", int'(vsync), int'(!(pvv >= VA + VFP && pvv < VA + VFP + VS)));
      end else begin
        check("video_on_rst", int'(video_on), 0);
        check("vga_pixel_rst", int'(vga_pixel), 0);
        check("hsync_rst", int'(hsync), 1);
        check("vsync_rst", int'(vsync), 1);
      end
    end
  end

  // Literal timing pins: periods, pulse widths and edge positions on the small raster.
  logic rst_q = 1'b1;
  always @(posedge clk) rst_q <= rst;

  int mt = 0, last_fs = -1, hs_run = 0, vs_run = 0, vp_run = 0, vp_lines = 0, fs_mode = -1;
  bit seen_ce = 0;
  always @(negedge clk) begin
    if (rst_q) begin
      mt = 0; last_fs = -1; hs_run = 0; vs_run = 0; vp_run = 0; vp_lines = 0;
      fs_mode = -1; seen_ce = 0;
    end else begin
      mt++;
      if (pix_ce && !seen_ce) begin
        check("first_pix_ce_clk", mt, CD - 1);
        seen_ce = 1;
      end
      if (frame_start) begin
        check("frame_spacing", mt - last_fs, FRAME_CLKS);
        last_fs = mt;
        if (mode != 0 && mode == fs_mode) check("lit_lines_per_frame", vp_lines, VA);
        vp_lines = 0;
        fs_mode = mode;
      end
      if (!hsync) begin
        if (hs_run == 0) check("hsync_fall_pos", mt % (CD * HT), CD * (HA + HFP + 1));
        hs_run++;
      end else if (hs_run > 0) begin
        check("hsync_low_clks", hs_run, CD * HS);
        hs_run = 0;
      end
      if (!vsync) begin
        if (vs_run == 0) check("vsync_fall_pos", mt % FRAME_CLKS, CD * (HT * (VA + VFP) + 1));
        vs_run++;
      end else if (vs_run > 0) begin
        check("vsync_low_clks", vs_run, CD * HT * VS);
        vs_run = 0;
      end
      if (vga_pixel) begin
        vp_run++;
      end else if (vp_run > 0) begin
        if (mode == 1) check("tied_run_clks", vp_run, CD * HA);
        if (mode == 2) check("render_run_clks", vp_run, CD);
        vp_lines++;
        vp_run = 0;
      end
    end
  end

  // Renderer stand-in: updates pixel_in one clk after x changes.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       pixel_in = 1'($urandom_range(1, 0));
        1:       pixel_in = 1'b1;
        default: pixel_in = (x == 10'd5);
      endcase
    end
  end

  task automatic wait_fs();
    for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
      @(negedge clk);
      if (frame_start) return;
    end
    check("frame_start_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x"}, int'(x), 0);
    check({tag, "_y"}, int'(y), 0);
    check({tag, "_pix_ce"}, int'(pix_ce), 0);
    check({tag, "_video_on"}, int'(video_on), 0);
    check({tag, "_vga_pixel"}, int'(vga_pixel), 0);
    check({tag, "_hsync"}, int'(hsync), 1);
    check({tag, "_vsync"}, int'(vsync), 1);
  endtask

  bit found;
  initial begin
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_reset");
    found = 0;
    for (int i = 0; i < 4 * CD; i++) begin
      if (pix_ce) begin found = 1; break; end
      @(negedge clk);
    end
    check("first_pix_ce_seen", int'(found), 1);
    @(negedge clk);
    check("x_after_first_ce", int'(x), 1);

    repeat (2 * FRAME_CLKS + 10) @(posedge clk);

    wait_fs();
    @(posedge clk); #1 mode = 1;
    wait_fs(); wait_fs(); wait_fs();
    @(posedge clk); #1 mode = 2;
    wait_fs(); wait_fs(); wait_fs();
    @(posedge clk); #1 mode = 0;

    found = 0;
    for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
      @(negedge clk);
      if ((t / CD) % HT == 10 && (t / CD / HT) % VT == 4) begin found = 1; break; end
    end
    check("midline_point_seen", int'(found), 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midline_reset");

    repeat (2 * FRAME_CLKS + 20) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
